// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared mux_2x_2_1 SEL line for two requesters.
// Optional forced-release timeout is built when MUX_ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic REL_A,
  input  logic REL_B,
  output logic SEL,
  output logic GNT_A,
  output logic GNT_B,
  output logic BUSY,
  output logic TIMEOUT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] GRANT_A = 2'd2;
  localparam logic [1:0] GRANT_B = 2'd3;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES);

  logic [1:0] state, state_nx;
  logic       sel_nx;
  logic       last_b, last_b_nx;
  logic [3:0] guard_cnt, guard_nx;
  logic       win_b;
  logic       own_req, own_rel, oth_req;
  logic       in_b;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hold_cnt, hold_nx;
  logic        tmo_nx;
`endif

  // Tie goes to whoever did not own the mux last.
  assign win_b = REQ_B && (!REQ_A || !last_b);

  // In SETUP and GRANT, SEL already points at the current winner.
  assign in_b    = SEL;
  assign own_req = in_b ? REQ_B : REQ_A;
  assign own_rel = in_b ? REL_B : REL_A;
  assign oth_req = in_b ? REQ_A : REQ_B;

  assign BUSY = (state != IDLE);

  // Next-state, select and counter decisions.
  always_comb begin
    state_nx  = state;
    sel_nx    = SEL;
    last_b_nx = last_b;
    guard_nx  = guard_cnt;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_nx   = '0;
    tmo_nx    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          if (win_b == SEL) begin
            state_nx = win_b ? GRANT_B : GRANT_A;
          end else begin
            sel_nx   = win_b;
            state_nx = SETUP;
            guard_nx = '0;
          end
        end
      end
      SETUP: begin
        if (!own_req) begin
          state_nx = IDLE;
        end else if (guard_cnt >= GUARD_LAST) begin
          state_nx = in_b ? GRANT_B : GRANT_A;
        end else if (guard_cnt != 4'hF) begin
          guard_nx = guard_cnt + 4'd1;
        end
      end
      GRANT_A, GRANT_B: begin
`ifdef MUX_ARB_TIMEOUT_EN
        hold_nx = hold_cnt;
`endif
        if (own_rel || !own_req) begin
          state_nx  = IDLE;
          last_b_nx = in_b;
`ifdef MUX_ARB_TIMEOUT_EN
        end else if (oth_req && hold_cnt >= HOLD_LAST) begin
          state_nx  = IDLE;
          last_b_nx = in_b;
          tmo_nx    = 1'b1;
        end else if (hold_cnt != 16'hFFFF) begin
          hold_nx = hold_cnt + 16'd1;
`endif
        end
      end
    endcase
  end

  // State, select and grant registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      SEL       <= 1'b0;
      GNT_A     <= 1'b0;
      GNT_B     <= 1'b0;
      last_b    <= 1'b1;
      guard_cnt <= '0;
    end else begin
      state     <= state_nx;
      SEL       <= sel_nx;
      GNT_A     <= (state_nx == GRANT_A);
      GNT_B     <= (state_nx == GRANT_B);
      last_b    <= last_b_nx;
      guard_cnt <= guard_nx;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt <= '0;
      TIMEOUT  <= 1'b0;
    end else begin
      hold_cnt <= hold_nx;
      TIMEOUT  <= tmo_nx;
    end
  end
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (GUARD_CYCLES=2, MAX_HOLD=16).
// Expected values are hand-derived per step.
module tb_mux_sel_arbiter;

  logic CLK = 1'b0;
  logic RESET, REQ_A, REQ_B, REL_A, REL_B;
  logic SEL, GNT_A, GNT_B, BUSY, TIMEOUT;
  int   total = 0;
  int   bad   = 0;

  mux_sel_arbiter #(.GUARD_CYCLES(2), .MAX_HOLD(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REL_A(REL_A), .REL_B(REL_B),
    .SEL(SEL), .GNT_A(GNT_A), .GNT_B(GNT_B),
    .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic s, input logic ga,
                      input logic gb, input logic bz, input logic to);
    chk({tag, ".sel"}, SEL, s);
    chk({tag, ".gnt_a"}, GNT_A, ga);
    chk({tag, ".gnt_b"}, GNT_B, gb);
    chk({tag, ".busy"}, BUSY, bz);
    chk({tag, ".timeout"}, TIMEOUT, to);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    chk("excl", GNT_A & GNT_B, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0;
    REL_A = 1'b0; REL_B = 1'b0;
    tick(); tick();
    chk5("rst", 0, 0, 0, 0, 0);
    RESET = 1'b0;

    REQ_A = 1'b1;
    tick();
    chk5("a_only", 0, 1, 0, 1, 0);
    REL_A = 1'b1;
    tick();
    chk5("a_rel", 0, 0, 0, 0, 0);
    REL_A = 1'b0; REQ_A = 1'b0;
    tick();
    chk5("a_idle", 0, 0, 0, 0, 0);

    REQ_A = 1'b1;
    tick();
    chk("mid_gnt", GNT_A, 1'b1);
    RESET = 1'b1;
    tick();
    chk5("mid_rst1", 0, 0, 0, 0, 0);
    tick(); tick();
    chk5("mid_rst3", 0, 0, 0, 0, 0);
    RESET = 1'b0; REQ_A = 1'b0;
    tick();
    chk5("post_rst", 0, 0, 0, 0, 0);

    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    chk5("tie_a", 0, 1, 0, 1, 0);
    tick();
    chk("tie_hold", GNT_A, 1'b1);
    REL_A = 1'b1; REQ_A = 1'b0;
    tick();
    chk5("tie_rel", 0, 0, 0, 0, 0);
    REL_A = 1'b0;
    tick();
    chk5("b_setup1", 1, 0, 0, 1, 0);
    tick();
    chk5("b_setup2", 1, 0, 0, 1, 0);
    tick();
    chk5("b_setup3", 1, 0, 0, 1, 0);
    tick();
    chk5("b_gnt", 1, 0, 1, 1, 0);
    REQ_B = 1'b0;
    tick();
    chk5("b_drop", 1, 0, 0, 0, 0);

    REQ_A = 1'b1;
    tick();
    chk5("a_setup", 0, 0, 0, 1, 0);
    tick(); tick();
    chk("a_setup3", GNT_A, 1'b0);
    tick();
    chk5("a_gnt", 0, 1, 0, 1, 0);
    REQ_A = 1'b0; REQ_B = 1'b1;
    tick();
    chk5("a_drop", 0, 0, 0, 0, 0);
    tick();
    chk5("ab_setup", 1, 0, 0, 1, 0);
    REQ_B = 1'b0;
    tick();
    chk5("abort", 1, 0, 0, 0, 0);
    tick();
    chk5("abort_idle", 1, 0, 0, 0, 0);

    REQ_A = 1'b1;
    tick();
    chk("a2_setup", SEL, 1'b0);
    tick(); tick(); tick();
    chk5("a2_gnt", 0, 1, 0, 1, 0);
    REQ_B = 1'b1; REL_B = 1'b1;
    tick();
    chk5("stray_relb", 0, 1, 0, 1, 0);
    REL_A = 1'b1;
    tick();
    chk5("rel_both", 0, 0, 0, 0, 0);
    REL_A = 1'b0; REL_B = 1'b0; REQ_A = 1'b0;
    tick();
    chk5("rearb", 1, 0, 0, 1, 0);
    tick(); tick(); tick();
    chk5("b2_gnt", 1, 0, 1, 1, 0);

    REQ_A = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("hold_b", GNT_B, 1'b1);
    end
    tick();
    chk5("tmo", 1, 0, 0, 0, 1);
    tick();
    chk5("tmo_setup", 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    chk5("tmo_a_gnt", 0, 1, 0, 1, 0);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("no_tmo_b", GNT_B, 1'b1);
      chk("no_tmo", TIMEOUT, 1'b0);
    end
    chk5("no_tmo_end", 1, 0, 1, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
